// File: rtl/gradient_accumulator_if.sv
// Gradient stream into the accumulator and averaged-gradient stream out of it.
interface gradient_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int IW     = 2
);
  logic              grad_valid_in;
  logic [DATA_W-1:0] grad_in;
  logic              clear_in;
  logic              grad_ready_out;
  logic [DATA_W-1:0] grad_out;
  logic [IW-1:0]     grad_index_out;
  logic              grad_descent_start_out;
  logic              batch_done_out;

  modport master (
    output grad_valid_in, grad_in, clear_in,
    input  grad_ready_out, grad_out, grad_index_out, grad_descent_start_out, batch_done_out
  );
  modport slave (
    input  grad_valid_in, grad_in, clear_in,
    output grad_ready_out, grad_out, grad_index_out, grad_descent_start_out, batch_done_out
  );
endinterface

// File: rtl/gradient_accumulator.sv
// Sums Q8.8 gradients per weight over 2^BATCH_LOG2 samples, then drains the
// shifted averages one per cycle toward the gradient descent stage.
module grad_acc_cell #(
  parameter int DATA_W = 16,
  parameter int AW     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] grad,
  output logic [AW-1:0]     acc
);
  logic signed [DATA_W-1:0] g;
  logic signed [AW-1:0]     g_ext, acc_s;
  assign g     = grad;
  assign g_ext = g;
  assign acc_s = acc;

  always_ff @(posedge clk or posedge rst)
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= acc_s + g_ext;
endmodule

module gradient_accumulator #(
  parameter int DEPTH      = 4,
  parameter int BATCH_LOG2 = 2,
  parameter int DATA_W     = 16,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW = (BATCH_LOG2 > 0) ? BATCH_LOG2 : 1,
  localparam int AW = DATA_W + BATCH_LOG2,
  localparam int B  = 1 << BATCH_LOG2
) (
  input logic clk,
  input logic rst,
  gradient_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [IW-1:0]             elem_idx, drain_idx, idx_q;
  logic [SW-1:0]             sample_cnt;
  logic [DEPTH-1:0][AW-1:0]  acc;
  logic [DEPTH-1:0]          add_en, clr;
  logic                      accept, clr_all, drain_en;
  logic                      elem_last, samp_last, drain_last;
  logic signed [AW-1:0]      sel;
  logic [DATA_W-1:0]         grad_q;
  logic                      start_q, done_q;

  assign elem_last  = (elem_idx == IW'(DEPTH-1));
  assign samp_last  = (sample_cnt == SW'(B-1));
  assign drain_last = (drain_idx == IW'(DEPTH-1));

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    clr_all  = 1'b0;
    drain_en = 1'b0;
    case (state_q)
      ACCUM: begin
        // clear wins over a same-cycle valid element
        if (bus.clear_in) clr_all = 1'b1;
        else if (bus.grad_valid_in) begin
          accept = 1'b1;
          if (elem_last && samp_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_en = 1'b1;
        if (drain_last) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_cell
      assign add_en[i] = accept && (elem_idx == IW'(i));
      assign clr[i]    = clr_all || (drain_en && (drain_idx == IW'(i)));
      grad_acc_cell #(.DATA_W(DATA_W), .AW(AW)) u_cell (
        .clk(clk), .rst(rst), .add_en(add_en[i]), .clr(clr[i]),
        .grad(bus.grad_in), .acc(acc[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      elem_idx   <= '0;
      sample_cnt <= '0;
      drain_idx  <= '0;
    end else if (clr_all) begin
      elem_idx   <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      if (elem_last) begin
        elem_idx   <= '0;
        sample_cnt <= samp_last ? '0 : sample_cnt + SW'(1);
        if (samp_last) drain_idx <= '0;
      end else
        elem_idx <= elem_idx + IW'(1);
    end else if (drain_en)
      drain_idx <= drain_last ? '0 : drain_idx + IW'(1);

  // floor average: arithmetic shift of the widened sum always fits DATA_W
  assign sel = acc[drain_idx];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grad_q  <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= drain_en;
      done_q  <= drain_en && drain_last;
      if (drain_en) begin
        grad_q <= DATA_W'(sel >>> BATCH_LOG2);
        idx_q  <= drain_idx;
      end
    end

  assign bus.grad_ready_out         = (state_q == ACCUM);
  assign bus.grad_out               = grad_q;
  assign bus.grad_index_out         = idx_q;
  assign bus.grad_descent_start_out = start_q;
  assign bus.batch_done_out         = done_q;
endmodule
